// File: rtl/input_ctrl_pkg.sv
// Shared types and constants for the push-button input conditioning block.
package input_ctrl_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_RIGHT = 2'd1;
   localparam dir_t DIR_DOWN  = 2'd2;
   localparam dir_t DIR_LEFT  = 2'd3;

   localparam int BTN_UP      = 0;
   localparam int BTN_RIGHT   = 1;
   localparam int BTN_DOWN    = 2;
   localparam int BTN_LEFT    = 3;
   localparam int BTN_RESTART = 4;

   localparam int DEFAULT_DEBOUNCE_SAMPLES = 3;
   localparam int DEFAULT_QUEUE_DEPTH      = 2;

   // Opposite direction differs only in the upper encoding bit.
   function automatic dir_t dir_reverse(input dir_t d);
      return d ^ 2'b10;
   endfunction

endpackage

// File: rtl/input_ctrl_btn_debounce.sv
// One button: two-flop synchroniser followed by a vsync-sampled debounce counter.
module input_ctrl_btn_debounce
   import input_ctrl_pkg::*;
#(
   parameter int SAMPLES = DEFAULT_DEBOUNCE_SAMPLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   input  logic i_sample,
   output logic o_level
);

   localparam int CW = $clog2(SAMPLES + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          state_q;
   logic          state_d;

   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      if (i_sample) begin
         if (sync2_q != state_q) begin
            if (cnt_q == CW'(SAMPLES - 1)) begin
               state_d = ~state_q;
               cnt_d   = {CW{1'b0}};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end else begin
            cnt_d = {CW{1'b0}};
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         state_q <= 1'b0;
      end else begin
         sync1_q <= i_raw;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign o_level = state_q;

endmodule

// File: rtl/input_ctrl.sv
// Debounces the five game buttons and turns direction presses into a short
// queue of legal turns that the movement logic consumes one per game tick.
module input_ctrl
   import input_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_SAMPLES = DEFAULT_DEBOUNCE_SAMPLES,
   parameter int QUEUE_DEPTH      = DEFAULT_QUEUE_DEPTH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] i_btn,
   input  logic       i_vsync,
   input  logic       i_tick,
   output logic       o_up,
   output logic       o_down,
   output logic       o_restart,
   output dir_t       o_dir,
   output logic       o_dir_changed
);

   localparam int CW = $clog2(QUEUE_DEPTH + 1);

   logic [4:0]                 deb;
   logic [3:0]                 rise;
   logic [3:0]                 deb_prev_q;
   logic                       press_valid_q;
   logic                       press_valid_d;
   dir_t                       press_dir_q;
   dir_t                       press_dir_d;
   dir_t [QUEUE_DEPTH-1:0]     queue_q;
   dir_t [QUEUE_DEPTH-1:0]     queue_d;
   dir_t [QUEUE_DEPTH-1:0]     shifted;
   logic [CW-1:0]              count_q;
   logic [CW-1:0]              count_d;
   logic [CW-1:0]              count_pop;
   dir_t                       dir_q;
   dir_t                       dir_d;
   logic                       changed_q;
   logic                       changed_d;
   dir_t                       ref_dir;
   logic                       pop;
   logic                       push;
   logic                       legal;

   for (genvar g = 0; g < 5; g++) begin : g_btn
      input_ctrl_btn_debounce #(.SAMPLES(DEBOUNCE_SAMPLES)) u_deb (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_raw    (i_btn[g]),
         .i_sample (i_vsync),
         .o_level  (deb[g])
      );
   end

   // Simultaneous presses collapse to one, up having the highest priority.
   always_comb begin
      rise          = deb[3:0] & ~deb_prev_q;
      press_valid_d = 1'b1;
      press_dir_d   = DIR_UP;
      if (rise[BTN_UP]) begin
         press_dir_d = DIR_UP;
      end else if (rise[BTN_RIGHT]) begin
         press_dir_d = DIR_RIGHT;
      end else if (rise[BTN_DOWN]) begin
         press_dir_d = DIR_DOWN;
      end else if (rise[BTN_LEFT]) begin
         press_dir_d = DIR_LEFT;
      end else begin
         press_valid_d = 1'b0;
      end
   end

   // A turn is judged against the last queued direction, else the current one.
   always_comb begin
      pop     = i_tick && (count_q != {CW{1'b0}});
      ref_dir = dir_q;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         ref_dir = (count_q == CW'(i + 1)) ? queue_q[i] : ref_dir;
      end
      legal     = press_valid_q && (press_dir_q != ref_dir) &&
                  (press_dir_q != dir_reverse(ref_dir));
      push      = legal && ((count_q != CW'(QUEUE_DEPTH)) || pop);
      count_pop = pop ? (count_q - CW'(1)) : count_q;
      shifted   = pop ? (queue_q >> 2'd2) : queue_q;

      if (deb[BTN_RESTART]) begin
         queue_d   = {QUEUE_DEPTH{DIR_UP}};
         count_d   = {CW{1'b0}};
         dir_d     = DIR_RIGHT;
         changed_d = 1'b0;
      end else begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            queue_d[i] = (push && (count_pop == CW'(i))) ? press_dir_q : shifted[i];
         end
         count_d   = push ? (count_pop + CW'(1)) : count_pop;
         dir_d     = pop ? queue_q[0] : dir_q;
         changed_d = pop;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deb_prev_q    <= 4'b0000;
         press_valid_q <= 1'b0;
         press_dir_q   <= DIR_UP;
         queue_q       <= {QUEUE_DEPTH{DIR_UP}};
         count_q       <= {CW{1'b0}};
         dir_q         <= DIR_RIGHT;
         changed_q     <= 1'b0;
      end else begin
         deb_prev_q    <= deb[3:0];
         press_valid_q <= press_valid_d;
         press_dir_q   <= press_dir_d;
         queue_q       <= queue_d;
         count_q       <= count_d;
         dir_q         <= dir_d;
         changed_q     <= changed_d;
      end
   end

   assign o_up          = deb[BTN_UP];
   assign o_down        = deb[BTN_DOWN];
   assign o_restart     = deb[BTN_RESTART];
   assign o_dir         = dir_q;
   assign o_dir_changed = changed_q;

endmodule

// File: tb/tb_input_ctrl.sv
// Directed self-checking bench for input_ctrl with default parameters.
module tb_input_ctrl;
   import input_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] i_btn;
   logic       i_vsync;
   logic       i_tick;
   logic       o_up;
   logic       o_down;
   logic       o_restart;
   dir_t       o_dir;
   logic       o_dir_changed;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   input_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_btn         (i_btn),
      .i_vsync       (i_vsync),
      .i_tick        (i_tick),
      .o_up          (o_up),
      .o_down        (o_down),
      .o_restart     (o_restart),
      .o_dir         (o_dir),
      .o_dir_changed (o_dir_changed)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic vs();
      i_vsync = 1'b1;
      cyc(1);
      i_vsync = 1'b0;
   endtask

   // Returns one cycle after the vsync edge on which the new level latches.
   task automatic debounce_to(input logic [4:0] b);
      i_btn = b;
      cyc(3);
      repeat (3) vs();
   endtask

   task automatic press(input int idx);
      logic [4:0] b;
      b      = i_btn;
      b[idx] = 1'b1;
      debounce_to(b);
      b[idx] = 1'b0;
      debounce_to(b);
   endtask

   task automatic tick_pulse();
      i_tick = 1'b1;
      cyc(1);
      i_tick = 1'b0;
   endtask

   initial begin
      logic [6:0] pat;
      rst_n   = 1'b0;
      i_btn   = 5'b11111;
      i_vsync = 1'b0;
      i_tick  = 1'b0;
      cyc(2);
      check("rst_up", 8'(o_up), 8'd0);
      check("rst_down", 8'(o_down), 8'd0);
      check("rst_restart", 8'(o_restart), 8'd0);
      check("rst_changed", 8'(o_dir_changed), 8'd0);
      check("rst_dir", 8'(o_dir), 8'd1);

      rst_n = 1'b1;
      cyc(3);
      vs();
      vs();
      check("held_up_2vs", 8'(o_up), 8'd0);
      vs();
      check("held_up_3vs", 8'(o_up), 8'd1);
      check("held_restart_3vs", 8'(o_restart), 8'd1);
      check("held_down_3vs", 8'(o_down), 8'd1);
      cyc(1);
      check("held_dir", 8'(o_dir), 8'd1);
      debounce_to(5'b00000);
      check("rel_up", 8'(o_up), 8'd0);
      check("rel_restart", 8'(o_restart), 8'd0);

      // Bounce: 1,0,1,0 then three stable highs.
      pat = 7'b1110101;
      for (int i = 0; i < 7; i++) begin
         i_btn[0] = pat[i];
         cyc(3);
         vs();
         check("bounce_up", 8'(o_up), (i == 6) ? 8'd1 : 8'd0);
      end
      cyc(3);
      i_btn = 5'b00000;
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      check("rst2_up", 8'(o_up), 8'd0);
      tick_pulse();
      check("rst2_changed", 8'(o_dir_changed), 8'd0);
      check("rst2_dir", 8'(o_dir), 8'd1);

      press(BTN_LEFT);
      press(BTN_RIGHT);
      tick_pulse();
      check("rev_changed", 8'(o_dir_changed), 8'd0);
      check("rev_dir", 8'(o_dir), 8'd1);

      press(BTN_UP);
      press(BTN_LEFT);
      press(BTN_DOWN);
      tick_pulse();
      check("fill_dir1", 8'(o_dir), 8'd0);
      check("fill_chg1", 8'(o_dir_changed), 8'd1);
      cyc(1);
      check("fill_chg_pulse", 8'(o_dir_changed), 8'd0);
      tick_pulse();
      check("fill_dir2", 8'(o_dir), 8'd3);
      check("fill_chg2", 8'(o_dir_changed), 8'd1);
      tick_pulse();
      check("fill_dir3", 8'(o_dir), 8'd3);
      check("fill_chg3", 8'(o_dir_changed), 8'd0);

      press(BTN_UP);
      press(BTN_LEFT);
      i_btn[BTN_DOWN] = 1'b1;
      cyc(3);
      repeat (3) vs();
      cyc(1);
      tick_pulse();
      check("sim_dir1", 8'(o_dir), 8'd0);
      check("sim_chg1", 8'(o_dir_changed), 8'd1);
      tick_pulse();
      check("sim_dir2", 8'(o_dir), 8'd3);
      tick_pulse();
      check("sim_dir3", 8'(o_dir), 8'd2);
      check("sim_chg3", 8'(o_dir_changed), 8'd1);
      tick_pulse();
      check("sim_chg4", 8'(o_dir_changed), 8'd0);
      debounce_to(5'b00000);

      press(BTN_RIGHT);
      tick_pulse();
      check("pre_dir_right", 8'(o_dir), 8'd1);
      press(BTN_UP);
      tick_pulse();
      check("pre_dir_up", 8'(o_dir), 8'd0);
      press(BTN_LEFT);
      press(BTN_DOWN);
      debounce_to(5'b10001);
      check("rs_up", 8'(o_up), 8'd1);
      check("rs_restart", 8'(o_restart), 8'd1);
      cyc(1);
      check("rs_dir", 8'(o_dir), 8'd1);
      check("rs_changed", 8'(o_dir_changed), 8'd0);
      tick_pulse();
      check("rs_tick_changed", 8'(o_dir_changed), 8'd0);
      check("rs_tick_dir", 8'(o_dir), 8'd1);
      debounce_to(5'b00000);
      check("rs_rel_restart", 8'(o_restart), 8'd0);
      tick_pulse();
      check("rs_flushed_changed", 8'(o_dir_changed), 8'd0);
      check("rs_flushed_dir", 8'(o_dir), 8'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/input_ctrl.md
Name: input_ctrl

Overview:
- Conditions the five raw push-buttons (up, right, down, left, restart) into clean signals for the rest of the game.
- Provides debounced level outputs for up, down and restart; these feed tickgen's i_up, i_down and i_restart.
- Turns direction-button presses into a small queue of legal direction changes. The snake movement logic consumes one change per game tick.

Parameters:
- DEBOUNCE_SAMPLES, 3: number of consecutive vsync samples that must disagree with the debounced state before it flips (range 1..15).
- QUEUE_DEPTH, 2: number of pending direction changes that can be buffered (range 1..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- i_btn  in  5  raw asynchronous buttons: bit0 up, bit1 right, bit2 down, bit3 left, bit4 restart
- i_vsync  in  1  single-cycle pulse per frame; this is the debounce sample strobe
- i_tick  in  1  game tick from tickgen; pops one queued direction
- o_up  out  1  debounced up level
- o_down  out  1  debounced down level
- o_restart  out  1  debounced restart level
- o_dir  out  2  current snake direction (dir_t)
- o_dir_changed  out  1  one-cycle pulse when o_dir is updated by a pop

Behaviour:
- Reset (rst_n low at a clk edge):
  - synchronisers, debounced states, counters and queue are all cleared.
  - o_up, o_down, o_restart and o_dir_changed are 0; o_dir is DIR_RIGHT.
  - Reset mid-debounce or with a non-empty queue discards all pending state.
- Synchroniser: each i_btn bit passes through a 2-flop synchroniser, giving sync[4:0].
- Debounce (per button):
  - Each button has a counter of width clog2(DEBOUNCE_SAMPLES+1).
  - On a cycle with i_vsync=1: if sync differs from the debounced state, the counter increments. When it reaches DEBOUNCE_SAMPLES, the debounced state toggles and the counter clears.
  - On a cycle with i_vsync=1 where sync equals the debounced state, the counter clears.
  - Cycles with i_vsync=0 hold the counter.
  - A debounced change is visible on outputs one cycle after the qualifying vsync edge.
- Level outputs: o_up, o_down and o_restart are the debounced states of bits 0, 2 and 4. They are driven regardless of restart.
- Press events:
  - A press is a 0->1 transition of a debounced direction bit, registered one cycle later.
  - If several presses occur in the same cycle, only one is taken, by priority up > right > down > left; the rest are dropped.
- Queue push:
  - The reference direction is the tail entry if the queue is non-empty, otherwise o_dir. Use pre-pop state.
  - A press equal to the reference, or equal to its reverse (reference ^ 2'b10), is discarded.
  - Otherwise the press is pushed if there is space. If the queue is full and no pop happens that cycle, the press is discarded.
  - Full with a simultaneous pop: the push is accepted.
- Queue pop (i_tick=1 and queue non-empty):
  - o_dir <= head, the queue advances, and o_dir_changed pulses for exactly one cycle.
  - i_tick with an empty queue leaves o_dir unchanged and gives no pulse.
- Restart: while debounced restart = 1, the queue is flushed every cycle, o_dir is forced to DIR_RIGHT, pushes are ignored, and o_dir_changed = 0.
- Count arithmetic: the occupancy counter cannot overflow or underflow. Push and pop in the same cycle leave the count unchanged.

Decomposition:
- Shared package (common):
  - typedef dir_t as logic [1:0], with DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3.
  - Button index constants BTN_UP..BTN_RESTART.
  - DEFAULT_DEBOUNCE_SAMPLES.
- Sub-module btn_debounce: one bit of synchroniser plus counter plus debounced state, instantiated 5 times.
- Queue and arbitration stay in input_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with i_btn=5'b11111 -> all outputs 0 and o_dir=1; released with buttons held, o_up rises only after 3 vsync pulses.
- Bounce: i_btn[0] toggles 1,0,1 across consecutive vsync pulses, then stays 1 for 3 pulses -> o_up stays 0 until the 3rd stable pulse, then rises 1 cycle later.
- Reversal and duplicate: o_dir=RIGHT; press left, then press right -> queue stays empty, i_tick gives no o_dir_changed.
- Queue fill (depth 2):
  - From o_dir=RIGHT, press up, left, down -> queue holds UP, LEFT; the down press is dropped.
  - Three ticks give o_dir = 0, 3, 3, with o_dir_changed pulses on the first two ticks only.
- Simultaneous: queue full (UP, LEFT); press down in the same cycle as i_tick -> o_dir=UP, queue = LEFT, DOWN.
- Restart: queue holds 2 entries, o_dir=UP; debounced restart=1 while holding up -> queue empty, o_dir=RIGHT, o_up=1, o_restart=1, and i_tick causes no change.
